morph_5x5: RTL and testbench
============================

Name: morph_5x5

Overview:
- Grayscale 5x5 morphological filter (erosion or dilation) placed directly downstream of the shift_custom line buffer.
- Consumes the five vertically aligned row taps px1..px5 of each pixel column.
- Emits one filtered pixel per input pixel at a fixed 3-cycle latency, ready for the VGA output path.
- Uses a separable min/max structure: a column reduction, then a row reduction.

Parameters:
- ROW, 30, frame height in lines (rows per frame).
- COL, 30, frame width in pixels (valid samples per line).
- DW, 8, pixel data width.
- MODE, 0, 0 = erosion (min of 25 pixels), 1 = dilation (max of 25 pixels).
- BORDER_VAL, 0, value driven on dout when the 5x5 window is incomplete.

Ports:
- vga_clk  input  1  pixel clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- px1  input  DW  row tap y-4 (oldest line).
- px2  input  DW  row tap y-3.
- px3  input  DW  row tap y-2.
- px4  input  DW  row tap y-1.
- px5  input  DW  row tap y (current line).
- px_vld  input  1  px1..px5 valid this cycle; arbitrary gaps allowed.
- dout  output  DW  filtered pixel for window centre (x-2, y-2).
- dout_vld  output  1  dout valid strobe.

Behaviour:
- Reset (async assert, sync release): dout=0, dout_vld=0, column and row counters=0, all pipeline valids=0, column-result registers cm[0..4]=0.
- Counters:
  - col_cnt advances 0..COL-1 on each px_vld.
  - At col_cnt==COL-1, col_cnt wraps to 0 and row_cnt increments.
  - row_cnt wraps 0 at ROW-1 when col_cnt also wraps.
  - The counters tag each sample with its input position (x,y).
- S1, cycle after px_vld: colres = min(px1..px5) for MODE 0, or max for MODE 1. Register colres with its (x,y) tag; set vld1.
- S2, on vld1: shift colres into cm (cm[0] newest, cm[4] oldest). Forward the tag; set vld2.
- S3, on vld2:
  - If x<4 or y<4, dout=BORDER_VAL.
  - Otherwise dout=min(cm[0..4]) for MODE 0, or max for MODE 1.
  - dout_vld=1 for exactly one cycle.
- Latency: dout_vld asserts exactly 3 cycles after the px_vld that produced it. Count of dout_vld equals count of px_vld.
- Gaps: pipeline stages advance only on their valid. Idle input cycles insert idle output cycles and do not alter data.
- Line boundary: cm is not cleared. Stale values from the previous line are masked by the x<4 border rule.
- Frame wrap: the first pixel after (COL-1, ROW-1) is tagged (0,0), with no dead cycle.
- Comparisons are unsigned. Equal values give the same result regardless of order. No width growth.
- Reset mid-frame: outputs clear immediately. The next px_vld after release is treated as (0,0).

Optional Feature:
- Macro MORPH_FRAME_DONE_EN.
- When defined:
  - Adds output port frame_done (1 bit, reset 0).
  - frame_done pulses high for one cycle, coincident with the dout_vld carrying tag (COL-1, ROW-1).
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package morph_pkg holds:
  - MODE_ERODE=0 and MODE_DILATE=1 constants.
  - WIN=5 and HALF=2 constants.
  - A counter-width function clog2-style for ROW/COL.
- One natural sub-module: morph_reduce5, a combinational 5-input min/max selected by MODE. It is instantiated twice, for the column stage and the row stage.

Test Plan:
- Flat frame, ROW=COL=30, MODE=0, all px=200:
  - dout=0 for y<4 or x<4 and 200 elsewhere.
  - Exactly 900 dout_vld pulses.
  - Each pulse arrives 3 cycles after its px_vld.
- Dark dot, MODE=0, all px=255 except px3=10 at input (x=10, y=10):
  - dout=10 for the outputs tagged x=10..14, y=10.
  - dout=255 for all other non-border outputs.
- Bright dot, MODE=1, all px=20 except px5=240 at (x=12, y=6): dout=240 for outputs tagged x=12..16, y=6.
- Gapped valid: repeat the dark-dot stimulus with 2 idle cycles after every px_vld. The output value sequence must be identical to the gapless run, with a 3-cycle latency per sample.
- Reset mid-frame: assert rst_n=0 at (x=12, y=7).
  - dout and dout_vld go 0 immediately.
  - After release, the first 4 lines of outputs are BORDER_VAL.
- Frame wrap with MORPH_FRAME_DONE_EN:
  - frame_done pulses once per 900 inputs, on the output tagged (29, 29).
  - The following output is tagged (0,0) and is border.

Source files
------------

// File: rtl/morph_pkg.sv
// Shared constants and helpers for the 5x5 morphological filter.
package morph_pkg;

    localparam int unsigned MODE_ERODE  = 0;
    localparam int unsigned MODE_DILATE = 1;
    localparam int unsigned WIN         = 5;
    localparam int unsigned HALF        = 2;

    // Minimum counter width able to hold values 0..n-1 (at least 1 bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/morph_5x5_if.sv
// Pixel-tap input bundle and filtered-pixel output bundle of morph_5x5.
// Optional macro MORPH_FRAME_DONE_EN adds the frame_done strobe.
interface morph_5x5_if #(
    parameter int unsigned DW = 8
);
    logic [DW-1:0] px1;
    logic [DW-1:0] px2;
    logic [DW-1:0] px3;
    logic [DW-1:0] px4;
    logic [DW-1:0] px5;
    logic          px_vld;
    logic [DW-1:0] dout;
    logic          dout_vld;
`ifdef MORPH_FRAME_DONE_EN
    logic          frame_done;

    modport master (output px1, px2, px3, px4, px5, px_vld,
                    input  dout, dout_vld, frame_done);
    modport slave  (input  px1, px2, px3, px4, px5, px_vld,
                    output dout, dout_vld, frame_done);
`else
    modport master (output px1, px2, px3, px4, px5, px_vld,
                    input  dout, dout_vld);
    modport slave  (input  px1, px2, px3, px4, px5, px_vld,
                    output dout, dout_vld);
`endif
endinterface

// File: rtl/morph_reduce5.sv
// Combinational 5-input unsigned min (erode) or max (dilate) selector.
module morph_reduce5
    import morph_pkg::*;
#(
    parameter int unsigned DW   = 8,
    parameter int unsigned MODE = MODE_ERODE
) (
    input  logic [WIN-1:0][DW-1:0] i_d,
    output logic [DW-1:0]          o_q
);

    // Linear scan keeping the running extreme; ties keep the earlier value.
    always_comb begin
        o_q = i_d[0];
        for (int unsigned i = 1; i < WIN; i++) begin
            if (MODE == MODE_DILATE) begin
                if (i_d[i] > o_q) o_q = i_d[i];
            end else begin
                if (i_d[i] < o_q) o_q = i_d[i];
            end
        end
    end

endmodule

// File: rtl/morph_5x5.sv
// 5x5 grayscale erosion/dilation behind the 5-tap line buffer.
// Separable: column min/max of the 5 taps, then row min/max over the
// last 5 column results; 3-cycle latency, one output per input.
// Optional macro MORPH_FRAME_DONE_EN adds a frame_done pulse on the
// output tagged (COL-1, ROW-1).
module morph_5x5
    import morph_pkg::*;
#(
    parameter int unsigned   ROW        = 30,
    parameter int unsigned   COL        = 30,
    parameter int unsigned   DW         = 8,
    parameter int unsigned   MODE       = MODE_ERODE,
    parameter logic [DW-1:0] BORDER_VAL = '0
) (
    input logic         vga_clk,
    input logic         rst_n,
    morph_5x5_if.slave  bus
);

    localparam int unsigned    CW       = cnt_w(COL);
    localparam int unsigned    RW       = cnt_w(ROW);
    localparam logic [CW-1:0]  COL_LAST = CW'(COL - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(ROW - 1);
    localparam logic [CW-1:0]  X_MIN    = CW'(WIN - 1);
    localparam logic [RW-1:0]  Y_MIN    = RW'(WIN - 1);

    logic [CW-1:0]          r_col_cnt;
    logic [RW-1:0]          r_row_cnt;

    logic [WIN-1:0][DW-1:0] w_col_taps;
    logic [DW-1:0]          w_colres;
    logic [DW-1:0]          w_rowres;

    logic                   r_vld1;
    logic [DW-1:0]          r_colres;
    logic [CW-1:0]          r_x1;
    logic [RW-1:0]          r_y1;

    logic                   r_vld2;
    logic [WIN-1:0][DW-1:0] r_cm;
    logic [CW-1:0]          r_x2;
    logic [RW-1:0]          r_y2;

    logic [DW-1:0]          r_dout;
    logic                   r_dout_vld;
    logic                   r_frame_done;

    // Gather the vertical column of taps, oldest line at index 0.
    always_comb begin
        w_col_taps[0] = bus.px1;
        w_col_taps[1] = bus.px2;
        w_col_taps[2] = bus.px3;
        w_col_taps[3] = bus.px4;
        w_col_taps[4] = bus.px5;
    end

    morph_reduce5 #(.DW(DW), .MODE(MODE)) u_col_reduce (
        .i_d (w_col_taps),
        .o_q (w_colres)
    );

    morph_reduce5 #(.DW(DW), .MODE(MODE)) u_row_reduce (
        .i_d (r_cm),
        .o_q (w_rowres)
    );

    // Input position counters: tag each accepted sample with (x, y).
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (bus.px_vld) begin
            if (r_col_cnt == COL_LAST) begin
                r_col_cnt <= '0;
                r_row_cnt <= (r_row_cnt == ROW_LAST) ? '0 : r_row_cnt + 1'b1;
            end else begin
                r_col_cnt <= r_col_cnt + 1'b1;
            end
        end
    end

    // Stage 1: register the column reduction with its position tag.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld1   <= 1'b0;
            r_colres <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
        end else begin
            r_vld1 <= bus.px_vld;
            if (bus.px_vld) begin
                r_colres <= w_colres;
                r_x1     <= r_col_cnt;
                r_y1     <= r_row_cnt;
            end
        end
    end

    // Stage 2: shift column result into the 5-deep window (cm[0] newest).
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld2 <= 1'b0;
            r_cm   <= '0;
            r_x2   <= '0;
            r_y2   <= '0;
        end else begin
            r_vld2 <= r_vld1;
            if (r_vld1) begin
                r_cm <= {r_cm[WIN-2:0], r_colres};
                r_x2 <= r_x1;
                r_y2 <= r_y1;
            end
        end
    end

    // Stage 3: row reduction, border masking hides stale previous-line columns.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_dout_vld   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_dout_vld   <= r_vld2;
            r_frame_done <= r_vld2 && (r_x2 == COL_LAST) && (r_y2 == ROW_LAST);
            if (r_vld2) begin
                r_dout <= ((r_x2 < X_MIN) || (r_y2 < Y_MIN)) ? BORDER_VAL : w_rowres;
            end
        end
    end

    assign bus.dout     = r_dout;
    assign bus.dout_vld = r_dout_vld;

`ifdef MORPH_FRAME_DONE_EN
    assign bus.frame_done = r_frame_done;
`else
    logic w_unused_fd;
    assign w_unused_fd = r_frame_done;
`endif

endmodule

// File: tb/tb_morph_5x5.sv
// Self-checking bench for morph_5x5: an erode instance (border 0) and a
// dilate instance (border 0x11) fed identical taps, checked against a
// frame-level reference model plus table vectors and corner sequences.
module tb_morph_5x5;

    localparam int ROW = 30;
    localparam int COL = 30;
    localparam logic [7:0] BV1 = 8'h11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    morph_5x5_if #(.DW(8)) bus0 ();
    morph_5x5_if #(.DW(8)) bus1 ();

    morph_5x5 #(.ROW(ROW), .COL(COL), .DW(8), .MODE(0), .BORDER_VAL(8'h00)) dut0 (
        .vga_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus0)
    );

    morph_5x5 #(.ROW(ROW), .COL(COL), .DW(8), .MODE(1), .BORDER_VAL(BV1)) dut1 (
        .vga_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus1)
    );

    int total = 0;
    int bad   = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] e0;
        logic [7:0] e1;
        bit         last;
        longint     c;
    } exp_t;

    logic [7:0] mem [ROW][COL][5];
    exp_t q[$];
    exp_t mon_e;
    int mx = 0, my = 0;
    int n_out = 0, n_10 = 0, n_240 = 0, n_fd = 0;
    bit rec_en = 0;
    logic [7:0] rec[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            mx = 0;
            my = 0;
        end else begin
            check("vld_pair", bus1.dout_vld, bus0.dout_vld);
            if (bus0.dout_vld) begin
                n_out++;
                if (bus0.dout == 8'd10)  n_10++;
                if (bus1.dout == 8'd240) n_240++;
                if (rec_en) rec.push_back(bus0.dout);
                if (q.size() == 0) begin
                    check("spurious_vld", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    check("dout_erode", bus0.dout, mon_e.e0);
                    check("dout_dilate", bus1.dout, mon_e.e1);
                    check("latency", cyc - mon_e.c, 3);
`ifdef MORPH_FRAME_DONE_EN
                    check("frame_done", bus0.frame_done, mon_e.last);
                    check("frame_done_d", bus1.frame_done, mon_e.last);
                    if (bus0.frame_done) n_fd++;
`endif
                end
            end else begin
`ifdef MORPH_FRAME_DONE_EN
                check("frame_done_idle", bus0.frame_done, 0);
`endif
                if (q.size() != 0 && (cyc - q[0].c) >= 3) begin
                    check("missing_vld", 0, 1);
                    mon_e = q.pop_front();
                end
            end
            if (bus0.px_vld) begin
                mem[my][mx][0] = bus0.px1;
                mem[my][mx][1] = bus0.px2;
                mem[my][mx][2] = bus0.px3;
                mem[my][mx][3] = bus0.px4;
                mem[my][mx][4] = bus0.px5;
                if (mx < 4 || my < 4) begin
                    mon_e.e0 = 8'h00;
                    mon_e.e1 = BV1;
                end else begin
                    mon_e.e0 = 8'hFF;
                    mon_e.e1 = 8'h00;
                    for (int i = 0; i < 5; i++)
                        for (int t = 0; t < 5; t++) begin
                            if (mem[my][mx-i][t] < mon_e.e0) mon_e.e0 = mem[my][mx-i][t];
                            if (mem[my][mx-i][t] > mon_e.e1) mon_e.e1 = mem[my][mx-i][t];
                        end
                end
                mon_e.last = (mx == COL-1) && (my == ROW-1);
                mon_e.c    = cyc;
                q.push_back(mon_e);
                if (mx == COL-1) begin
                    mx = 0;
                    my = (my == ROW-1) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_px(input logic [4:0][7:0] p, input logic v);
        bus0.px1 = p[0]; bus0.px2 = p[1]; bus0.px3 = p[2]; bus0.px4 = p[3]; bus0.px5 = p[4];
        bus1.px1 = p[0]; bus1.px2 = p[1]; bus1.px3 = p[2]; bus1.px4 = p[3]; bus1.px5 = p[4];
        bus0.px_vld = v;
        bus1.px_vld = v;
    endtask

    task automatic drive(input logic [4:0][7:0] p);
        @(posedge clk); #1;
        set_px(p, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus0.px_vld = 1'b0;
            bus1.px_vld = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        idle(1);
        while (q.size() != 0 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, q.size(), 0);
    endtask

    // kind: 0 flat 200, 1 dark dot, 2 bright dot, 3 random; gap<0 = random 0..2
    task automatic feed_frame(input int kind, input int gap, input int stop_x, input int stop_y);
        logic [4:0][7:0] p;
        int g;
        for (int y = 0; y < ROW; y++)
            for (int x = 0; x < COL; x++) begin
                if (x == stop_x && y == stop_y) return;
                case (kind)
                    0: p = {5{8'd200}};
                    1: begin
                        p = {5{8'd255}};
                        if (x == 10 && y == 10) p[2] = 8'd10;
                    end
                    2: begin
                        p = {5{8'd20}};
                        if (x == 12 && y == 6) p[4] = 8'd240;
                    end
                    default: for (int t = 0; t < 5; t++) p[t] = 8'($urandom_range(0, 255));
                endcase
                drive(p);
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                if (g > 0) idle(g);
            end
    endtask

    task automatic do_reset();
        idle(1);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
    endtask

    typedef struct {
        logic [4:0][7:0] taps;
        logic [7:0]      emin;
        logic [7:0]      emax;
    } vec_t;

    vec_t tbl[6];
    logic [7:0] rec_a[$];

    initial begin : main
        int ndiff;
        tbl[0].taps = {8'd50,  8'd40,  8'd30,  8'd20,  8'd10};  tbl[0].emin = 8'd10;  tbl[0].emax = 8'd50;
        tbl[1].taps = {8'd200, 8'd200, 8'd200, 8'd3,   8'd200}; tbl[1].emin = 8'd3;   tbl[1].emax = 8'd200;
        tbl[2].taps = {8'd1,   8'd127, 8'd128, 8'd255, 8'd0};   tbl[2].emin = 8'd0;   tbl[2].emax = 8'd255;
        tbl[3].taps = {8'd77,  8'd77,  8'd77,  8'd77,  8'd77};  tbl[3].emin = 8'd77;  tbl[3].emax = 8'd77;
        tbl[4].taps = {8'd251, 8'd252, 8'd253, 8'd254, 8'd255}; tbl[4].emin = 8'd251; tbl[4].emax = 8'd255;
        tbl[5].taps = {8'd9,   8'd8,   8'd100, 8'd8,   8'd9};   tbl[5].emin = 8'd8;   tbl[5].emax = 8'd100;

        set_px('0, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout0", bus0.dout, 0);
        check("rst_dout1", bus1.dout, 0);
        check("rst_vld0", bus0.dout_vld, 0);
        check("rst_vld1", bus1.dout_vld, 0);
        rst_n = 1'b1;
        idle(1);

        // flat frame
        n_out = 0;
        feed_frame(0, 0, -1, -1);
        drain("drain_flat");
        check("flat_count", n_out, 900);
        check("flat_last0", bus0.dout, 200);
        check("flat_last1", bus1.dout, 200);

        // dark dot gapless, then gapped; frames follow back to back (wrap)
        n_10 = 0;
        rec.delete();
        rec_en = 1;
        feed_frame(1, 0, -1, -1);
        drain("drain_dark");
        rec_en = 0;
        check("dark_hits", n_10, 5);
        rec_a = rec;

        n_10 = 0;
        rec.delete();
        rec_en = 1;
        feed_frame(1, 2, -1, -1);
        drain("drain_dark_gap");
        rec_en = 0;
        check("dark_gap_hits", n_10, 5);
        check("gap_seq_len", rec.size(), rec_a.size());
        ndiff = 0;
        for (int i = 0; i < rec.size() && i < rec_a.size(); i++)
            if (rec[i] != rec_a[i]) ndiff++;
        check("gap_seq_diff", ndiff, 0);

        // bright dot, dilation
        n_240 = 0;
        feed_frame(2, 0, -1, -1);
        drain("drain_bright");
        check("bright_hits", n_240, 5);

        // random frames with random gaps
        feed_frame(3, -1, -1, -1);
        feed_frame(3, -1, -1, -1);
        drain("drain_rand");
`ifdef MORPH_FRAME_DONE_EN
        check("frame_done_count", n_fd, 6);
`endif

        // mid-frame reset at (12,7)
        feed_frame(3, 0, 12, 7);
        @(posedge clk); #1;
        set_px('0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_dout0", bus0.dout, 0);
        check("midrst_dout1", bus1.dout, 0);
        check("midrst_vld0", bus0.dout_vld, 0);
        check("midrst_vld1", bus1.dout_vld, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        n_out = 0;
        feed_frame(3, -1, -1, -1);
        drain("drain_after_rst");
        check("after_rst_count", n_out, 900);

        // table vectors on row 4 of a fresh frame
        do_reset();
        feed_frame(3, 0, 0, 4);
        for (int v = 0; v < 6; v++) begin
            repeat (5) drive(tbl[v].taps);
            idle(4);
            check("tbl_erode", bus0.dout, tbl[v].emin);
            check("tbl_dilate", bus1.dout, tbl[v].emax);
        end
        drain("drain_tbl");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule
